// File: rtl/register_access_initiator_pkg.sv
// Shared constants and FSM encoding for the local register bus initiator.
package register_access_initiator_pkg;
  localparam int REG_ADDR_W    = 19;
  localparam int REG_DATA_W    = 32;
  localparam int WAIT_CNT_W    = 10;
  localparam int TIMEOUT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_e;
endpackage

// File: rtl/register_access_initiator.sv
// Register bus master: one host command at a time, single-cycle bus strobe,
// read-return capture with timeout, result handed back upstream.
module register_access_initiator
  import register_access_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_rd,
  input  logic [REG_ADDR_W-1:0]    iv_cmd_addr,
  input  logic                     i_cmd_addr_fixed,
  input  logic [REG_DATA_W-1:0]    iv_cmd_wdata,
  output logic                     o_wr,
  output logic                     o_rd,
  output logic [REG_ADDR_W-1:0]    ov_addr,
  output logic                     o_addr_fixed,
  output logic [REG_DATA_W-1:0]    ov_wdata,
  input  logic                     i_rsp_wr,
  input  logic [REG_ADDR_W-1:0]    iv_rsp_addr,
  input  logic                     i_rsp_addr_fixed,
  input  logic [REG_DATA_W-1:0]    iv_rsp_rdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [REG_ADDR_W-1:0]    ov_rsp_addr,
  output logic [REG_DATA_W-1:0]    ov_rsp_rdata,
  output logic                     o_rsp_timeout,
  output logic [TIMEOUT_CNT_W-1:0] ov_timeout_cnt
);

  localparam logic [WAIT_CNT_W-1:0]    WAIT_LAST  = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] TO_CNT_MAX = {TIMEOUT_CNT_W{1'b1}};
  localparam logic [REG_ADDR_W-1:0]    ADDR_ZERO  = {REG_ADDR_W{1'b0}};
  localparam logic [REG_DATA_W-1:0]    DATA_ZERO  = {REG_DATA_W{1'b0}};

  state_e                   state_r;
  state_e                   state_nxt_s;
  logic                     accept_s;
  logic                     rsp_match_s;
  logic                     expire_s;
  logic                     op_rd_r;
  logic [REG_ADDR_W-1:0]    addr_r;
  logic                     addr_fixed_r;
  logic [WAIT_CNT_W-1:0]    wait_cnt_r;
  logic                     wr_r;
  logic                     rd_r;
  logic [REG_ADDR_W-1:0]    bus_addr_r;
  logic                     bus_addr_fixed_r;
  logic [REG_DATA_W-1:0]    bus_wdata_r;
  logic                     rsp_valid_r;
  logic [REG_ADDR_W-1:0]    rsp_addr_r;
  logic [REG_DATA_W-1:0]    rsp_rdata_r;
  logic                     rsp_timeout_r;
  logic [TIMEOUT_CNT_W-1:0] timeout_cnt_r;

  assign o_cmd_ready = (state_r == IDLE);
  assign accept_s    = (state_r == IDLE) & i_cmd_valid;
  assign rsp_match_s = i_rsp_wr & (iv_rsp_addr == addr_r) & (i_rsp_addr_fixed == addr_fixed_r);
  assign expire_s    = (wait_cnt_r == WAIT_LAST);

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_cmd_valid) state_nxt_s = ISSUE;
        else             state_nxt_s = IDLE;
      end
      ISSUE: begin
        if (op_rd_r) state_nxt_s = WAIT_RSP;
        else         state_nxt_s = IDLE;
      end
      WAIT_RSP: begin
        if (rsp_match_s || expire_s) state_nxt_s = RESP;
        else                         state_nxt_s = WAIT_RSP;
      end
      RESP: begin
        if (i_rsp_ready) state_nxt_s = IDLE;
        else             state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Command latch and bus drive; loading on acceptance keeps the bus live only in ISSUE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_rd_r          <= 1'b0;
      addr_r           <= ADDR_ZERO;
      addr_fixed_r     <= 1'b0;
      wr_r             <= 1'b0;
      rd_r             <= 1'b0;
      bus_addr_r       <= ADDR_ZERO;
      bus_addr_fixed_r <= 1'b0;
      bus_wdata_r      <= DATA_ZERO;
      wait_cnt_r       <= {WAIT_CNT_W{1'b0}};
    end else begin
      wr_r             <= accept_s & ~i_cmd_rd;
      rd_r             <= accept_s & i_cmd_rd;
      bus_addr_r       <= accept_s ? iv_cmd_addr : ADDR_ZERO;
      bus_addr_fixed_r <= accept_s & i_cmd_addr_fixed;
      bus_wdata_r      <= (accept_s & ~i_cmd_rd) ? iv_cmd_wdata : DATA_ZERO;
      if (accept_s) begin
        op_rd_r      <= i_cmd_rd;
        addr_r       <= iv_cmd_addr;
        addr_fixed_r <= i_cmd_addr_fixed;
      end
      if (state_r == ISSUE)         wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      else if (state_r == WAIT_RSP) wait_cnt_r <= wait_cnt_r + 10'd1;
    end
  end

  // Upstream result; a match in the expiry cycle takes priority over the timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_r   <= 1'b0;
      rsp_addr_r    <= ADDR_ZERO;
      rsp_rdata_r   <= DATA_ZERO;
      rsp_timeout_r <= 1'b0;
      timeout_cnt_r <= {TIMEOUT_CNT_W{1'b0}};
    end else if ((state_r == WAIT_RSP) && rsp_match_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_addr_r    <= addr_r;
      rsp_rdata_r   <= iv_rsp_rdata;
      rsp_timeout_r <= 1'b0;
    end else if ((state_r == WAIT_RSP) && expire_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_addr_r    <= addr_r;
      rsp_rdata_r   <= DATA_ZERO;
      rsp_timeout_r <= 1'b1;
      if (timeout_cnt_r != TO_CNT_MAX) timeout_cnt_r <= timeout_cnt_r + 16'd1;
    end else if ((state_r == RESP) && i_rsp_ready) begin
      rsp_valid_r   <= 1'b0;
    end
  end

  assign o_wr           = wr_r;
  assign o_rd           = rd_r;
  assign ov_addr        = bus_addr_r;
  assign o_addr_fixed   = bus_addr_fixed_r;
  assign ov_wdata       = bus_wdata_r;
  assign o_rsp_valid    = rsp_valid_r;
  assign ov_rsp_addr    = rsp_addr_r;
  assign ov_rsp_rdata   = rsp_rdata_r;
  assign o_rsp_timeout  = rsp_timeout_r;
  assign ov_timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_register_access_initiator.sv
// Self-checking bench for register_access_initiator: directed vector table,
// hand-written corner sequences and randomized transactions against a reference model.
module tb_register_access_initiator;

  localparam int TC = 16;

  typedef struct {
    logic        rd;
    logic [18:0] addr;
    logic        fixed;
    logic [31:0] wdata;
    int          rsp_dly;     // response in cycle T+1+rsp_dly; 0 = none
    logic [31:0] rsp_data;
    int          spur_dly;    // non-matching return in cycle T+1+spur_dly; 0 = none
    logic [18:0] spur_xor;
    logic        spur_flip;
    int          ready_dly;   // cycles of i_rsp_ready low while result is valid
    int          exp_lat;     // cycle offset of o_rsp_valid; 0 = no result
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_rd = 1'b0, cmd_fixed = 1'b0;
  logic [18:0] cmd_addr = 19'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_wr = 1'b0, rsp_fixed = 1'b0, rsp_ready = 1'b0;
  logic [18:0] rsp_addr = 19'd0;
  logic [31:0] rsp_rdata = 32'd0;
  logic        cmd_ready, wr, rd, addr_fixed, rsp_valid, rsp_timeout;
  logic [18:0] addr, rsp_addr_o;
  logic [31:0] wdata, rsp_rdata_o;
  logic [15:0] timeout_cnt;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_to_cnt = 16'd0;
  vec_t        vecs[10];

  register_access_initiator #(.TIMEOUT_CYCLES(TC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rd(cmd_rd),
    .iv_cmd_addr(cmd_addr), .i_cmd_addr_fixed(cmd_fixed), .iv_cmd_wdata(cmd_wdata),
    .o_wr(wr), .o_rd(rd), .ov_addr(addr), .o_addr_fixed(addr_fixed), .ov_wdata(wdata),
    .i_rsp_wr(rsp_wr), .iv_rsp_addr(rsp_addr), .i_rsp_addr_fixed(rsp_fixed),
    .iv_rsp_rdata(rsp_rdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .ov_rsp_addr(rsp_addr_o),
    .ov_rsp_rdata(rsp_rdata_o), .o_rsp_timeout(rsp_timeout), .ov_timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock step; the read-return strobe defaults low each cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    rsp_wr = 1'b0;
  endtask

  task automatic drive_rsp(input logic [18:0] a, input logic f, input logic [31:0] d);
    rsp_wr = 1'b1; rsp_addr = a; rsp_fixed = f; rsp_rdata = d;
  endtask

  task automatic chk_all_reset(input string nm);
    chk({nm, " strobes"}, 64'({cmd_ready, wr, rd, addr_fixed, rsp_valid, rsp_timeout}), 64'(6'b100000));
    chk({nm, " bus addr/data"}, 64'({addr, wdata}), 64'd0);
    chk({nm, " rsp addr/data"}, 64'({rsp_addr_o, rsp_rdata_o}), 64'd0);
    chk({nm, " timeout_cnt"}, 64'(timeout_cnt), 64'd0);
  endtask

  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    if (!v.rd) begin
      r.exp_lat = 0; r.exp_rdata = 32'd0; r.exp_to = 1'b0;
    end else if (v.rsp_dly >= 1 && v.rsp_dly <= TC) begin
      r.exp_lat = 2 + v.rsp_dly; r.exp_rdata = v.rsp_data; r.exp_to = 1'b0;
    end else begin
      r.exp_lat = 2 + TC; r.exp_rdata = 32'd0; r.exp_to = 1'b1;
    end
    return r;
  endfunction

  task automatic run_txn(input string nm, input vec_t v);
    int lat = -1;
    bit seen = 1'b0;
    chk({nm, " cmd_ready@T"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_rd = v.rd; cmd_addr = v.addr; cmd_fixed = v.fixed; cmd_wdata = v.wdata;
    tick();
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_fixed = ~v.fixed; cmd_wdata = ~v.wdata;
    chk({nm, " wr/rd@T+1"}, 64'({wr, rd}), 64'({~v.rd, v.rd}));
    chk({nm, " addr@T+1"}, 64'({addr_fixed, addr}), 64'({v.fixed, v.addr}));
    chk({nm, " wdata@T+1"}, 64'(wdata), v.rd ? 64'd0 : 64'(v.wdata));
    chk({nm, " cmd_ready@T+1"}, 64'(cmd_ready), 64'd0);
    if (!v.rd) begin
      if (v.spur_dly > 0) drive_rsp(v.addr, v.fixed, 32'hBAD0_0000);
      tick();
      chk({nm, " wr post"}, 64'({wr, rd, addr, wdata}), 64'd0);
      chk({nm, " no rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({nm, " cmd_ready@T+2"}, 64'(cmd_ready), 64'd1);
    end else begin
      for (int k = 2; k <= 40 && !seen; k++) begin
        tick();
        if (v.rsp_dly > 0 && k == 1 + v.rsp_dly)
          drive_rsp(v.addr, v.fixed, v.rsp_data);
        else if (v.spur_dly > 0 && k == 1 + v.spur_dly)
          drive_rsp(v.addr ^ v.spur_xor, v.fixed ^ v.spur_flip, 32'hDEAD_0000 ^ v.rsp_data);
        chk($sformatf("%s bus idle@T+%0d", nm, k), 64'({wr, rd, addr_fixed, addr, wdata}), 64'd0);
        if (rsp_valid) begin
          seen = 1'b1; lat = k;
        end
      end
      chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
      if (seen) begin
        if (v.exp_to && exp_to_cnt != 16'hFFFF) exp_to_cnt = exp_to_cnt + 16'd1;
        for (int i = 0; i <= v.ready_dly; i++) begin
          if (i > 0) tick();
          chk($sformatf("%s valid hold %0d", nm, i), 64'({rsp_valid, cmd_ready}), 64'(2'b10));
          chk($sformatf("%s rdata %0d", nm, i), 64'(rsp_rdata_o), 64'(v.exp_rdata));
          chk($sformatf("%s rsp addr/to %0d", nm, i), 64'({rsp_timeout, rsp_addr_o}), 64'({v.exp_to, v.addr}));
          chk($sformatf("%s timeout_cnt %0d", nm, i), 64'(timeout_cnt), 64'(exp_to_cnt));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({nm, " after handshake"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
      end
    end
  endtask

  initial begin
    // rd, addr, fixed, wdata, rsp_dly, rsp_data, spur_dly, spur_xor, spur_flip, ready_dly, exp_lat, exp_rdata, exp_to
    vecs[0] = '{1'b0, 19'd5,      1'b1, 32'h0000_0123, 0,  32'h0,         0, 19'd0,     1'b0, 0, 0,  32'h0,         1'b0};
    vecs[1] = '{1'b1, 19'd4,      1'b0, 32'hFFFF_FFFF, 1,  32'h0000_0002, 0, 19'd0,     1'b0, 0, 3,  32'h0000_0002, 1'b0};
    vecs[2] = '{1'b1, 19'd9,      1'b0, 32'h0,         0,  32'h0,         0, 19'd0,     1'b0, 0, 18, 32'h0,         1'b1};
    vecs[3] = '{1'b1, 19'd2,      1'b0, 32'h0,         3,  32'h0000_0B0B, 1, 19'd1,     1'b0, 0, 5,  32'h0000_0B0B, 1'b0};
    vecs[4] = '{1'b1, 19'h12345,  1'b1, 32'h0,         2,  32'hA5A5_5A5A, 0, 19'd0,     1'b0, 5, 4,  32'hA5A5_5A5A, 1'b0};
    vecs[5] = '{1'b1, 19'h7FFFF,  1'b1, 32'h0,         16, 32'hFFFF_FFFF, 0, 19'd0,     1'b0, 0, 18, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{1'b1, 19'h00100,  1'b0, 32'h0,         17, 32'h1234_5678, 0, 19'd0,     1'b0, 0, 18, 32'h0,         1'b1};
    vecs[7] = '{1'b1, 19'd7,      1'b1, 32'h0,         2,  32'h0000_0077, 1, 19'd0,     1'b1, 1, 4,  32'h0000_0077, 1'b0};
    vecs[8] = '{1'b0, 19'h7FFFF,  1'b0, 32'hDEAD_BEEF, 0,  32'h0,         1, 19'd0,     1'b0, 0, 0,  32'h0,         1'b0};
    vecs[9] = '{1'b1, 19'h40001,  1'b0, 32'h0,         15, 32'h0F0F_0F0F, 14, 19'h40000, 1'b0, 2, 17, 32'h0F0F_0F0F, 1'b0};

    #12;
    chk_all_reset("in reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk_all_reset("after reset");

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back posted writes: one strobe every two cycles.
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 19'(100 + i); cmd_fixed = 1'(i); cmd_wdata = 32'(32'h1000 * (i + 1));
      chk($sformatf("b2b%0d ready", i), 64'(cmd_ready), 64'd1);
      tick();
      chk($sformatf("b2b%0d strobe", i), 64'({wr, rd, addr_fixed, addr}), 64'({2'b10, 1'(i), 19'(100 + i)}));
      chk($sformatf("b2b%0d wdata", i), 64'(wdata), 64'(32'h1000 * (i + 1)));
      tick();
      chk($sformatf("b2b%0d gap", i), 64'({wr, cmd_ready}), 64'(2'b01));
    end
    cmd_valid = 1'b0;

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.rd        = 1'($urandom_range(0, 1));
      v.addr      = 19'($urandom);
      v.fixed     = 1'($urandom_range(0, 1));
      v.wdata     = $urandom;
      v.rsp_dly   = int'($urandom_range(0, 18));
      v.rsp_data  = $urandom;
      v.spur_dly  = int'($urandom_range(0, 17));
      if (v.spur_dly == v.rsp_dly) v.spur_dly = 0;
      v.spur_xor  = 19'($urandom_range(1, 19'h7FFFF));
      v.spur_flip = 1'($urandom_range(0, 1));
      v.ready_dly = int'($urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", n), predict(v));
    end

    // Reset while waiting for a read return; the stale return must be ignored.
    chk("pre-reset timeout_cnt", 64'(timeout_cnt), 64'(exp_to_cnt));
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 19'd6; cmd_fixed = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_to_cnt = 16'd0;
    chk_all_reset("async reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rsp(19'd6, 1'b0, 32'h0000_0066);
      tick();
      chk($sformatf("stale rsp %0d", i), 64'({rsp_valid, cmd_ready, rsp_rdata_o}), 64'({2'b01, 32'h0}));
    end
    run_txn("post-reset", predict('{1'b1, 19'd6, 1'b0, 32'h0, 1, 32'h0000_0606, 0, 19'd0, 1'b0, 0, 0, 32'h0, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
